// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and helpers for the wait-stated register bank.
//   rf_state_t  - transfer FSM states (IDLE, WAIT, RESP)
//   rf_idx_w    - width of the word index for a given register count
//   strb_merge  - byte-lane merge of new data into an old word
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rf_state_t;

  // Widest register the merge helper handles; callers zero-extend into it
  // and truncate the result back to their own width.
  localparam int RF_MAX_DW = 256;

  // Wait-state counter width (supports 0..15 wait states).
  localparam int RF_CNT_W = 4;

  // Index width is clog2(depth), kept at least 1 so a single-register bank
  // still has a sliceable index (index 1 is then caught as out of range).
  function automatic int rf_idx_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Each byte lane with its strobe set takes the new byte, others keep old.
  function automatic logic [RF_MAX_DW-1:0] strb_merge(
    input logic [RF_MAX_DW-1:0]   old_v,
    input logic [RF_MAX_DW-1:0]   new_v,
    input logic [RF_MAX_DW/8-1:0] strb
  );
    logic [RF_MAX_DW-1:0] res;
    res = old_v;
    for (int b = 0; b < RF_MAX_DW / 8; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_ws_counter.sv
// ws_counter: loadable 4-bit down-counter that times the wait states.
//   clk      - clock
//   rst      - asynchronous active-low reset (count clears to 0)
//   load     - load load_val on the next rising edge
//   load_val - value to load
//   zero     - high while the count is 0
// The count decrements every cycle until it reaches 0 and then holds.
module ws_counter
  import reg_file_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [RF_CNT_W-1:0] load_val,
  output logic                zero
);

  logic [RF_CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/reg_file_ws.sv
// reg_file_ws: word-addressed register bank with byte strobes, programmable
// wait states, per-register read-only protection and a registered response.
//   clk      - clock, everything sampled on the rising edge
//   rst      - asynchronous active-low reset
//   rd_en    - read request
//   wr_en    - write request
//   address  - byte address; word index = address[IDX_W+1:2]
//   wr_data  - write data
//   wr_strb  - byte-lane write enables
//   rd_data  - registered read data, non-zero only in a read response cycle
//   ready    - low only while a transfer is waiting
//   error    - registered error flag, valid in the response cycle
// Parameters: DATA_WIDTH (multiple of 8, at most RF_MAX_DW), ADDR_WIDTH,
// REG_FILE_DEPTH, WAIT_STATES (0..15), RO_MASK (bit i = register i read-only).
module reg_file_ws
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 16,
  parameter int WAIT_STATES    = 0,
  parameter logic [REG_FILE_DEPTH-1:0] RO_MASK = {REG_FILE_DEPTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    ready,
  output logic                    error
);

  localparam int IDX_W    = rf_idx_w(REG_FILE_DEPTH);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int IDX_SPAN = 1 << IDX_W;

  // Depth and read-only mask widened to cover every encodable index.
  localparam logic [IDX_W:0]        DEPTH_L = (IDX_W + 1)'(REG_FILE_DEPTH);
  localparam logic [IDX_SPAN-1:0]   RO_EXT  = IDX_SPAN'(RO_MASK);
  localparam logic [RF_CNT_W-1:0]   WS_LOAD =
    (WAIT_STATES > 0) ? RF_CNT_W'(WAIT_STATES - 1) : '0;

  rf_state_t state_reg, state_next;

  logic accept;
  logic cnt_load;
  logic cnt_zero;

  // Request as seen at the commit edge.
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic                  c_rd;
  logic                  c_wr;
  logic                  commit;

  logic [IDX_W-1:0]      c_idx;
  logic                  range_err;
  logic                  align_err;
  logic                  both_err;
  logic                  ro_err;
  logic                  req_err;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [REG_FILE_DEPTH-1:0][DATA_WIDTH-1:0] mem_flat;

  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  error_reg;

  assign ready  = (state_reg != WAIT);
  assign accept = ready & (rd_en | wr_en);

  ws_counter u_ws_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WS_LOAD),
    .zero     (cnt_zero)
  );

  // With no wait states the accept edge is also the commit edge, so the
  // live inputs are committed directly. Otherwise the request is held in
  // registers until the counter expires.
  generate
    if (WAIT_STATES == 0) begin : g_direct
      assign c_addr = address;
      assign c_data = wr_data;
      assign c_strb = wr_strb;
      assign c_rd   = rd_en;
      assign c_wr   = wr_en;
      assign commit = accept;
    end else begin : g_latched
      logic [ADDR_WIDTH-1:0] req_addr_reg;
      logic [DATA_WIDTH-1:0] req_data_reg;
      logic [STRB_W-1:0]     req_strb_reg;
      logic                  req_rd_reg;
      logic                  req_wr_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          req_addr_reg <= '0;
          req_data_reg <= '0;
          req_strb_reg <= '0;
          req_rd_reg   <= 1'b0;
          req_wr_reg   <= 1'b0;
        end else if (accept) begin
          req_addr_reg <= address;
          req_data_reg <= wr_data;
          req_strb_reg <= wr_strb;
          req_rd_reg   <= rd_en;
          req_wr_reg   <= wr_en;
        end
      end

      assign c_addr = req_addr_reg;
      assign c_data = req_data_reg;
      assign c_strb = req_strb_reg;
      assign c_rd   = req_rd_reg;
      assign c_wr   = req_wr_reg;
      assign commit = (state_reg == WAIT) & cnt_zero;
    end
  endgenerate

  // Request decode and error classification.
  assign c_idx     = c_addr[IDX_W+1:2];
  assign range_err = ((c_addr >> (IDX_W + 2)) != '0) || ({1'b0, c_idx} >= DEPTH_L);
  assign align_err = (c_addr[1:0] != 2'b00);
  assign both_err  = c_rd & c_wr;
  assign ro_err    = c_wr & RO_EXT[c_idx];
  assign req_err   = range_err | align_err | both_err | ro_err;
  assign mem_we    = commit & c_wr & ~req_err;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REG_FILE_DEPTH; i++) begin
      if (c_idx == IDX_W'(i)) begin
        rd_word = mem_flat[i];
      end
    end
  end

  assign wr_word = DATA_WIDTH'(strb_merge(RF_MAX_DW'(rd_word),
                                          RF_MAX_DW'(c_data),
                                          (RF_MAX_DW / 8)'(c_strb)));

  // Registers are individual flops so the whole bank clears on reset.
  genvar gi;
  generate
    for (gi = 0; gi < REG_FILE_DEPTH; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_reg <= '0;
        end else if (mem_we && (c_idx == IDX_W'(gi))) begin
          word_reg <= wr_word;
        end
      end

      assign mem_flat[gi] = word_reg;
    end
  endgenerate

  // Transfer FSM.
  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_load   = 1'b1;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_load   = 1'b1;
          end else begin
            state_next = RESP;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Response registers: loaded on the edge entering RESP, cleared otherwise
  // so rd_data and error live for exactly one response cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      rd_data_reg <= '0;
      error_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (commit) begin
        error_reg   <= req_err;
        rd_data_reg <= (c_rd & ~req_err) ? rd_word : '0;
      end else begin
        error_reg   <= 1'b0;
        rd_data_reg <= '0;
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign error   = error_reg;

endmodule
